// File: rtl/sipo_frame_rx.sv
// Serial-in, parallel-out frame receiver: start/4 data (MSB first)/even parity/stop,
// sampled mid-bit, with one-cycle valid/perr/ferr pulses and registered outputs.
module sipo_frame_rx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sin,
  output logic qa,
  output logic qb,
  output logic qc,
  output logic qd,
  output logic valid,
  output logic perr,
  output logic ferr,
  output logic busy
);

  localparam int H  = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_HALF = CW'(H - 1);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_bit;
  logic [3:0]    r_shift;
  logic          r_par;

  logic w_tick;
  logic w_par_ok;

  assign w_tick   = (r_cnt == C_LAST);
  assign w_par_ok = ((^r_shift) ^ r_par) == 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      qa      <= 1'b0;
      qb      <= 1'b0;
      qc      <= 1'b0;
      qd      <= 1'b0;
      valid   <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      busy    <= 1'b0;
    end else begin
      valid <= 1'b0;
      perr  <= 1'b0;
      ferr  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!sin) begin
            r_state <= S_START;
            r_cnt   <= '0;
            busy    <= 1'b1;
          end
        end
        S_START: begin
          // Half-bit delay puts every later sample in the middle of its bit.
          if (r_cnt == C_HALF) begin
            r_cnt <= '0;
            if (sin) begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
            end else begin
              r_state <= S_DATA;
              r_bit   <= '0;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_shift <= {r_shift[2:0], sin};
            r_bit   <= r_bit + 1'b1;
            if (r_bit == 2'd3) r_state <= S_PARITY;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_PARITY: begin
          if (w_tick) begin
            r_cnt   <= '0;
            r_par   <= sin;
            r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            r_cnt <= '0;
            if (sin) begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
              if (w_par_ok) begin
                {qa, qb, qc, qd} <= r_shift;
                valid            <= 1'b1;
              end else begin
                perr <= 1'b1;
              end
            end else begin
              ferr    <= 1'b1;
              r_state <= S_WAIT_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_WAIT_IDLE: begin
          if (sin) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Self-checking bench for sipo_frame_rx: directed plus random line waveforms,
// expected outputs derived per cycle from the frame sample-point timing rules.
module tb_sipo_frame_rx;

  localparam int C    = 4;
  localparam int H    = C / 2;
  localparam int MAXN = 8000;

  logic clk = 1'b0;
  logic rst;
  logic sin;
  logic qa, qb, qc, qd, valid, perr, ferr, busy;

  sipo_frame_rx #(.CLKS_PER_BIT(C)) dut (
    .clk  (clk),
    .rst  (rst),
    .sin  (sin),
    .qa   (qa),
    .qb   (qb),
    .qc   (qc),
    .qd   (qd),
    .valid(valid),
    .perr (perr),
    .ferr (ferr),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Line waveform: index t is the value seen at clock edge t.
  logic       sin_w [MAXN];
  logic       rst_w [MAXN];
  // Expected outputs just after edge t.
  logic [3:0] eq [MAXN];
  logic       ev [MAXN];
  logic       ep [MAXN];
  logic       ef [MAXN];
  logic       eb [MAXN];

  int n      = 0;
  int n_cmp  = 0;
  int n_bad  = 0;
  int n_vexp = 0;
  int n_vgot = 0;

  task automatic put(input logic s, input logic r, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      if (n < MAXN) begin
        sin_w[n] = s;
        rst_w[n] = r;
        n++;
      end
    end
  endtask

  task automatic put_frame(input logic [3:0] w, input logic par_good,
                           input logic stopv, input int stop_w);
    logic p;
    p = par_good ? (^w) : ~(^w);
    put(1'b0, 1'b0, C);
    for (int k = 3; k >= 0; k--) put(w[k], 1'b0, C);
    put(p, 1'b0, C);
    put(stopv, 1'b0, stop_w);
  endtask

  task automatic set_exp(input int i, input logic [3:0] q, input logic v,
                         input logic p, input logic f, input logic b);
    eq[i] = q;
    ev[i] = v;
    ep[i] = p;
    ef[i] = f;
    eb[i] = b;
  endtask

  // Reference: scan the line for a start edge E0, then read bits at
  // E0+H+k*C (k=0 start, 1..4 data, 5 parity, 6 stop).
  task automatic build_expect();
    int t, u, e0, off, idx;
    logic [3:0] qcur, sh;
    logic pbit;
    t = 0; qcur = '0; sh = '0; pbit = 1'b0;
    while (t < n) begin
      if (rst_w[t]) begin
        qcur = '0;
        set_exp(t, qcur, 1'b0, 1'b0, 1'b0, 1'b0);
        t++;
      end else if (sin_w[t]) begin
        set_exp(t, qcur, 1'b0, 1'b0, 1'b0, 1'b0);
        t++;
      end else begin
        e0 = t;
        set_exp(t, qcur, 1'b0, 1'b0, 1'b0, 1'b1);
        u = t + 1;
        t = -1;
        while (u < n && t < 0) begin
          off = u - e0;
          if (rst_w[u]) begin
            t = u;
          end else if (off == H && sin_w[u]) begin
            set_exp(u, qcur, 1'b0, 1'b0, 1'b0, 1'b0);
            t = u + 1;
          end else if (off == H + 6 * C) begin
            if (sin_w[u]) begin
              if (((^sh) ^ pbit) == 1'b0) begin
                qcur = sh;
                set_exp(u, qcur, 1'b1, 1'b0, 1'b0, 1'b0);
              end else begin
                set_exp(u, qcur, 1'b0, 1'b1, 1'b0, 1'b0);
              end
              t = u + 1;
            end else begin
              set_exp(u, qcur, 1'b0, 1'b0, 1'b1, 1'b1);
              u++;
              while (u < n && t < 0) begin
                if (rst_w[u]) begin
                  t = u;
                end else if (sin_w[u]) begin
                  set_exp(u, qcur, 1'b0, 1'b0, 1'b0, 1'b0);
                  t = u + 1;
                end else begin
                  set_exp(u, qcur, 1'b0, 1'b0, 1'b0, 1'b1);
                  u++;
                end
              end
            end
          end else begin
            if (off > H && (off - H) % C == 0) begin
              idx = (off - H) / C;
              if (idx <= 4) sh[4-idx] = sin_w[u];
              else          pbit = sin_w[u];
            end
            set_exp(u, qcur, 1'b0, 1'b0, 1'b0, 1'b1);
            u++;
          end
        end
        if (t < 0) t = n;
      end
    end
  endtask

  initial begin
    logic       prev_rst;
    logic [3:0] w;
    int         kind;

    rst = 1'b1;
    sin = 1'b1;

    // Power-on reset and idle.
    put(1'b1, 1'b1, 3);
    put(1'b1, 1'b0, 5);
    // Reset asserted at E0+12 of a partial frame, then a clean 1010.
    put(1'b0, 1'b0, C);
    put(1'b1, 1'b0, C);
    put(1'b0, 1'b0, C);
    put(1'b1, 1'b1, 3);
    put(1'b1, 1'b0, 5);
    put_frame(4'b1010, 1'b1, 1'b1, C);
    put(1'b1, 1'b0, 3);
    // Good frames.
    put_frame(4'b1011, 1'b1, 1'b1, C); put(1'b1, 1'b0, 2);
    put_frame(4'b0000, 1'b1, 1'b1, C); put(1'b1, 1'b0, 2);
    put_frame(4'b0001, 1'b1, 1'b1, C); put(1'b1, 1'b0, 2);
    put_frame(4'b0111, 1'b1, 1'b1, C); put(1'b1, 1'b0, 2);
    put_frame(4'b1111, 1'b1, 1'b1, C); put(1'b1, 1'b0, 2);
    // Parity error.
    put_frame(4'b0110, 1'b0, 1'b1, C); put(1'b1, 1'b0, 3);
    // Framing error with line held low.
    put_frame(4'b0011, 1'b1, 1'b0, C); put(1'b0, 1'b0, 10); put(1'b1, 1'b0, 4);
    // False start glitch.
    put(1'b0, 1'b0, 1); put(1'b1, 1'b0, 6);
    // Back-to-back with minimum stop width.
    put_frame(4'b1001, 1'b1, 1'b1, H + 1);
    put_frame(4'b0101, 1'b1, 1'b1, H + 1);
    put(1'b1, 1'b0, 4);
    // Random traffic.
    for (int r = 0; r < 40; r++) begin
      w    = 4'($urandom_range(0, 15));
      kind = int'($urandom_range(0, 9));
      case (kind)
        0: begin
          put(1'b0, 1'b0, int'($urandom_range(1, H)));
          put(1'b1, 1'b0, 3);
        end
        1: put_frame(w, 1'b0, 1'b1, int'($urandom_range(H + 1, C + 2)));
        2: begin
          put_frame(w, 1'b1, 1'b0, C);
          put(1'b0, 1'b0, int'($urandom_range(0, 6)));
          put(1'b1, 1'b0, 2);
        end
        3: begin
          put(1'b0, 1'b0, C);
          put(w[3], 1'b0, int'($urandom_range(1, 3 * C)));
          put(1'b1, 1'b1, int'($urandom_range(1, 3)));
          put(1'b1, 1'b0, 2);
        end
        default: put_frame(w, 1'b1, 1'b1, int'($urandom_range(H + 1, C + 2)));
      endcase
      put(1'b1, 1'b0, int'($urandom_range(0, 5)));
    end
    put(1'b1, 1'b0, 4);

    build_expect();
    for (int t = 0; t < n; t++) if (ev[t]) n_vexp++;

    for (int t = 0; t < n; t++) begin
      @(negedge clk);
      prev_rst = rst;
      rst = rst_w[t];
      sin = sin_w[t];
      if (rst && !prev_rst) begin
        #1;
        n_cmp++;
        assert ({qa, qb, qc, qd, valid, perr, ferr, busy} === 8'h00)
        else begin
          n_bad++;
          $error("FAIL async_rst t=%0d got %b exp 00000000", t,
                 {qa, qb, qc, qd, valid, perr, ferr, busy});
        end
      end
      @(posedge clk);
      #1;
      if (valid === 1'b1) n_vgot++;
      n_cmp++;
      assert ({qa, qb, qc, qd} === eq[t])
      else begin
        n_bad++;
        $error("FAIL qword t=%0d got %b exp %b", t, {qa, qb, qc, qd}, eq[t]);
      end
      n_cmp++;
      assert ({valid, perr, ferr, busy} === {ev[t], ep[t], ef[t], eb[t]})
      else begin
        n_bad++;
        $error("FAIL flags(v,p,f,b) t=%0d got %b exp %b", t,
               {valid, perr, ferr, busy}, {ev[t], ep[t], ef[t], eb[t]});
      end
      n_cmp++;
      assert ((32'(valid) + 32'(perr) + 32'(ferr)) <= 32'd1)
      else begin
        n_bad++;
        $error("FAIL pulse_excl t=%0d got %b%b%b exp at most one high", t, valid, perr, ferr);
      end
    end

    n_cmp++;
    assert (n_vgot == n_vexp)
    else begin
      n_bad++;
      $error("FAIL valid_count got %0d exp %0d", n_vgot, n_vexp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
